w1_decode: RTL and testbench

W1_DECODE -- requirements
Module: w1_decode

---
 rtl/w1_pkg.sv | 26 ++
 rtl/w1_unpack_buf.sv | 63 ++++++
 rtl/w1_decode.sv | 145 ++++++++++++++
 tb/tb_w1_decode.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/w1_pkg.sv
// w1_pkg: shared FSM state type, default decoder parameters and sizing helpers
// for the w1 vector decoder.
package w1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } w1_state_t;

  localparam int K_DEF     = 32'sd8;
  localparam int Q_DEF     = 32'sd8380417;
  localparam int GAMMA_DEF = (Q_DEF - 32'sd1) / 32'sd32;
  localparam int WIDHT_DEF = 32'sd4;

  // Largest coefficient value that is legal for the given rounding range.
  function automatic int w1_max(input int q_v, input int gamma_v);
    return (q_v - 32'sd1) / (32'sd2 * gamma_v) - 32'sd1;
  endfunction

  // Number of 32-bit words carrying one packed vector of k polynomials.
  function automatic int w1_word_count(input int k_v, input int widht_v);
    return (32'sd256 * k_v * widht_v) / 32'sd32;
  endfunction

endpackage

// File: rtl/w1_unpack_buf.sv
// w1_unpack_buf: 64-bit LSB-first bit reservoir. A pop drops the lowest widht
// bits; a pushed word is appended directly above the remaining fill level.
module w1_unpack_buf
  import w1_pkg::*;
#(
  parameter int widht = WIDHT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [31:0]      in_data,
  output logic [widht-1:0] head,
  output logic [6:0]       cnt
);

  localparam logic [6:0] WIDHT_C = 7'(widht);

  logic [63:0] bits_r;
  logic [63:0] shifted_s;
  logic [63:0] bits_next_s;
  logic [6:0]  cnt_r;
  logic [6:0]  cnt_shift_s;
  logic [6:0]  cnt_next_s;

  // Pop shift is applied first so a same-cycle push lands on the post-pop fill level.
  always_comb begin
    shifted_s   = bits_r;
    cnt_shift_s = cnt_r;
    bits_next_s = bits_r;
    cnt_next_s  = cnt_r;
    if (pop) begin
      shifted_s   = bits_r >> widht;
      cnt_shift_s = cnt_r - WIDHT_C;
    end else begin
      shifted_s   = bits_r;
      cnt_shift_s = cnt_r;
    end
    if (push) begin
      bits_next_s = shifted_s | ({32'd0, in_data} << cnt_shift_s);
      cnt_next_s  = cnt_shift_s + 7'd32;
    end else begin
      bits_next_s = shifted_s;
      cnt_next_s  = cnt_shift_s;
    end
  end

  // Reservoir register; start clears it so no bits survive into a new vector.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      bits_r <= 64'd0;
      cnt_r  <= 7'd0;
    end else begin
      bits_r <= bits_next_s;
      cnt_r  <= cnt_next_s;
    end
  end

  assign head = bits_r[widht-1:0];
  assign cnt  = cnt_r;

endmodule

// File: rtl/w1_decode.sv
// w1_decode: unpacks a w1 vector (256*k coefficients of widht bits, LSB first)
// into indexed coefficients. Range check built only with W1_DECODE_RANGE_CHECK_EN.
module w1_decode
  import w1_pkg::*;
#(
  parameter int k     = K_DEF,
  parameter int q     = Q_DEF,
  parameter int gamma = GAMMA_DEF,
  parameter int widht = WIDHT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [widht-1:0]     coeff,
  output logic                 coeff_valid,
  input  logic                 coeff_ready,
  output logic [$clog2(k)-1:0] poly_idx,
  output logic [7:0]           coeff_idx,
  output logic                 coeff_last,
  output logic                 busy,
  output logic                 done,
  output logic                 range_err
);

  localparam int              PW        = $clog2(k);
  localparam int              NWORDS    = w1_word_count(k, widht);
  localparam int              WL_W      = $clog2(NWORDS + 1);
  localparam logic [6:0]      WIDHT_C   = 7'(widht);
  localparam logic [PW-1:0]   POLY_LAST = PW'(k - 1);
  localparam logic [WL_W-1:0] WL_LOAD   = WL_W'(NWORDS);

  w1_state_t         state_r;
  w1_state_t         state_next_s;
  logic [WL_W-1:0]   words_left_r;
  logic [PW-1:0]     poly_idx_r;
  logic [7:0]        coeff_idx_r;
  logic [6:0]        cnt_s;
  logic              run_s;
  logic              start_ok_s;
  logic              push_s;
  logic              pop_s;

  assign run_s      = (state_r == ST_RUN);
  assign start_ok_s = start && !run_s;
  assign push_s     = in_valid && in_ready;
  assign pop_s      = coeff_valid && coeff_ready;

  w1_unpack_buf #(.widht(widht)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_ok_s),
    .push    (push_s),
    .pop     (pop_s),
    .in_data (in_data),
    .head    (coeff),
    .cnt     (cnt_s)
  );

  // All handshake outputs decode registered state only, never the inputs.
  assign in_ready    = run_s && (cnt_s <= 7'd32) && (words_left_r != '0);
  assign coeff_valid = run_s && (cnt_s >= WIDHT_C);
  assign coeff_last  = coeff_valid && (poly_idx_r == POLY_LAST) && (coeff_idx_r == 8'd255);
  assign poly_idx    = poly_idx_r;
  assign coeff_idx   = coeff_idx_r;
  assign busy        = run_s;
  assign done        = (state_r == ST_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: start honoured outside RUN only; RUN ends on the final pop.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_RUN;
        else       state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (pop_s && coeff_last) state_next_s = ST_DONE;
        else                     state_next_s = ST_RUN;
      end
      ST_DONE: begin
        if (start) state_next_s = ST_RUN;
        else       state_next_s = ST_DONE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Word budget and coefficient position; coeff_idx wraps 255->0 into the next polynomial.
  always_ff @(posedge clk) begin
    if (reset) begin
      words_left_r <= '0;
      poly_idx_r   <= '0;
      coeff_idx_r  <= 8'd0;
    end else if (start_ok_s) begin
      words_left_r <= WL_LOAD;
      poly_idx_r   <= '0;
      coeff_idx_r  <= 8'd0;
    end else begin
      if (push_s) words_left_r <= words_left_r - WL_W'(1);
      if (pop_s) begin
        coeff_idx_r <= coeff_idx_r + 8'd1;
        if (coeff_idx_r == 8'd255) begin
          poly_idx_r <= (poly_idx_r == POLY_LAST) ? '0 : poly_idx_r + PW'(1);
        end
      end
    end
  end

`ifdef W1_DECODE_RANGE_CHECK_EN
  localparam logic [31:0] MAX_U = 32'(w1_max(q, gamma));

  logic range_err_r;
  logic over_s;

  assign over_s = ({{(32 - widht){1'b0}}, coeff} > MAX_U);

  // Sticky flag: set on popping an out-of-range coefficient, cleared by start.
  always_ff @(posedge clk) begin
    if (reset) begin
      range_err_r <= 1'b0;
    end else if (start_ok_s) begin
      range_err_r <= 1'b0;
    end else if (pop_s && over_s) begin
      range_err_r <= 1'b1;
    end
  end

  assign range_err = range_err_r;
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_w1_decode.sv
// tb_w1_decode: directed + randomised-gap bench for w1_decode with a bitstream-level
// reference model (k=8, widht=4) and hand-computed checks on a k=4, widht=6 instance.
module tb_w1_decode;

  localparam int K      = 8;
  localparam int W      = 4;
  localparam int Q      = 8380417;
  localparam int GAMMA  = (Q - 1) / 32;
  localparam int NW     = 256 * K * W / 32;
  localparam int TOTAL  = 256 * K;
  localparam int MAXC   = (Q - 1) / (2 * GAMMA) - 1;
  localparam int K6     = 4;
  localparam int W6     = 6;
  localparam int GAMMA6 = (Q - 1) / 88;
`ifdef W1_DECODE_RANGE_CHECK_EN
  localparam bit RANGE_ON = 1'b1;
`else
  localparam bit RANGE_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  coeff;
  logic        coeff_valid;
  logic        coeff_ready;
  logic [2:0]  poly_idx;
  logic [7:0]  coeff_idx;
  logic        coeff_last;
  logic        busy;
  logic        done;
  logic        range_err;

  logic        s6_start;
  logic [31:0] s6_in_data;
  logic        s6_in_valid;
  logic        s6_in_ready;
  logic [5:0]  s6_coeff;
  logic        s6_coeff_valid;
  logic        s6_coeff_ready;
  logic [1:0]  s6_poly_idx;
  logic [7:0]  s6_coeff_idx;
  logic        s6_coeff_last;
  logic        s6_busy;
  logic        s6_done;
  logic        s6_range_err;

  w1_decode #(.k(K), .q(Q), .gamma(GAMMA), .widht(W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .coeff(coeff),
    .coeff_valid(coeff_valid), .coeff_ready(coeff_ready), .poly_idx(poly_idx),
    .coeff_idx(coeff_idx), .coeff_last(coeff_last), .busy(busy), .done(done),
    .range_err(range_err)
  );

  w1_decode #(.k(K6), .q(Q), .gamma(GAMMA6), .widht(W6)) dut6 (
    .clk(clk), .reset(reset), .start(s6_start), .in_data(s6_in_data),
    .in_valid(s6_in_valid), .in_ready(s6_in_ready), .coeff(s6_coeff),
    .coeff_valid(s6_coeff_valid), .coeff_ready(s6_coeff_ready), .poly_idx(s6_poly_idx),
    .coeff_idx(s6_coeff_idx), .coeff_last(s6_coeff_last), .busy(s6_busy), .done(s6_done),
    .range_err(s6_range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the accepted word stream and how many coefficients were consumed.
  bit          m_run;
  bit          m_done;
  bit          m_err;
  logic [31:0] m_words[$];
  int          m_nin;
  int          m_pop;

  int n_checks;
  int n_errors;
  int cyc;
  int pops, words, lasts, first_acc, first_val, first_pop, last_pop, n6;
  int got6[7];
  int exp6[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_coeff(input int idx);
    int v;
    int b;
    logic [31:0] wd;
    v = 0;
    for (int j = 0; j < W; j++) begin
      b  = idx * W + j;
      wd = m_words[b / 32];
      if (wd[b % 32]) v = v | (1 << j);
    end
    return v;
  endfunction

  // Compare DUT outputs with the model, then advance the model by the inputs the next edge sees.
  task automatic model_step();
    int avail;
    bit e_ir, e_cv, e_last;
    int e_c;
    avail  = m_nin * 32 - m_pop * W;
    e_ir   = m_run && (avail <= 32) && (m_nin < NW);
    e_cv   = m_run && (avail >= W);
    e_last = e_cv && (m_pop == TOTAL - 1);
    e_c    = 0;
    chk("in_ready", 64'(in_ready), 64'(e_ir));
    chk("coeff_valid", 64'(coeff_valid), 64'(e_cv));
    chk("coeff_last", 64'(coeff_last), 64'(e_last));
    chk("busy", 64'(busy), 64'(m_run));
    chk("done", 64'(done), 64'(m_done));
    chk("range_err", 64'(range_err), 64'(m_err));
    chk("coeff_idx", 64'(coeff_idx), 64'(m_pop % 256));
    chk("poly_idx", 64'(poly_idx), 64'((m_pop / 256) % K));
    if (e_cv) begin
      e_c = model_coeff(m_pop);
      chk("coeff", 64'(coeff), 64'(e_c));
    end
    if (reset) begin
      m_run = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_words.delete(); m_nin = 0; m_pop = 0;
    end else if (start && !m_run) begin
      m_run = 1'b1; m_done = 1'b0; m_err = 1'b0;
      m_words.delete(); m_nin = 0; m_pop = 0;
    end else begin
      if (in_valid && e_ir) begin
        m_words.push_back(in_data);
        m_nin++;
      end
      if (e_cv && coeff_ready) begin
        if (RANGE_ON && e_c > MAXC) m_err = 1'b1;
        m_pop++;
        if (e_last) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    m_run = 1'b0; m_done = 1'b0; m_err = 1'b0; m_nin = 0; m_pop = 0;
    reset = 1'b1; start = 1'b0; in_data = 32'd0; in_valid = 1'b0; coeff_ready = 1'b0;
    s6_start = 1'b0; s6_in_data = 32'd0; s6_in_valid = 1'b0; s6_coeff_ready = 1'b0;
    exp6 = '{63, 63, 63, 63, 63, 51, 0};
    repeat (3) @(posedge clk);
    #1;

    // Reset state.
    chk("reset_flags", 64'({in_ready, coeff_valid, coeff_last, busy, done, range_err}), 64'd0);
    chk("reset_idx", 64'({poly_idx, coeff_idx}), 64'd0);
    reset = 1'b0;
    tick();

    // Full vector of 0x76543210 words with ready high.
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("in_ready_after_start", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_data = 32'h76543210; coeff_ready = 1'b1;
    pops = 0; words = 0; lasts = 0; first_acc = -1; first_val = -1; first_pop = -1; last_pop = -1;
    for (int t = 0; t < 4000 && !done; t++) begin
      if (in_valid && in_ready) begin
        words++;
        if (first_acc < 0) first_acc = cyc;
      end
      if (coeff_valid && first_val < 0) first_val = cyc;
      if (coeff_valid && coeff_ready) begin
        chk("pattern", 64'(coeff), 64'(pops % 8));
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (coeff_last) lasts++;
        pops++;
      end
      tick();
    end
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_pops", 64'(pops), 64'd2048);
    chk("t1_words", 64'(words), 64'd256);
    chk("t1_last_once", 64'(lasts), 64'd1);
    chk("t1_first_valid_latency", 64'(first_val), 64'(first_acc + 1));
    chk("t1_done_latency", 64'(cyc), 64'(last_pop + 1));
    chk("t1_throughput", 64'(last_pop - first_pop + 1), 64'd2048);
    chk("t1_range_err", 64'(range_err), 64'd0);

    // Restart from DONE, then a start pulse while running must be ignored.
    in_valid = 1'b0; coeff_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_done_clear", 64'(done), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    chk("restart_idx", 64'(coeff_idx), 64'd0);
    in_valid = 1'b1; coeff_ready = 1'b1;
    repeat (20) tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("start_in_run_busy", 64'(busy), 64'd1);
    chk("start_in_run_ignored", 64'(coeff_idx), 64'd20);

    // Output stall of 10 cycles with input still offered.
    coeff_ready = 1'b0;
    repeat (10) tick();
    chk("stall_in_ready_low", 64'(in_ready), 64'd0);
    chk("stall_valid_held", 64'(coeff_valid), 64'd1);
    chk("stall_idx_held", 64'(coeff_idx), 64'd20);
    chk("stall_coeff_held", 64'(coeff), 64'd4);
    coeff_ready = 1'b1;
    for (int t = 0; t < 4000 && !done; t++) tick();
    chk("t3_done", 64'(done), 64'd1);

    // Reset after 100 pops of all-ones data, then a clean restart.
    in_data = 32'hFFFFFFFF;
    start = 1'b1; tick(); start = 1'b0;
    pops = 0;
    for (int t = 0; t < 400 && pops < 100; t++) begin
      if (coeff_valid && coeff_ready) pops++;
      tick();
    end
    chk("t4_pops", 64'(pops), 64'd100);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midreset_flags", 64'({in_ready, coeff_valid, coeff_last, busy, done, range_err}), 64'd0);
    chk("midreset_idx", 64'({poly_idx, coeff_idx}), 64'd0);
    in_valid = 1'b0; coeff_ready = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    in_data = 32'h76543210; in_valid = 1'b1;
    for (int t = 0; t < 10 && !coeff_valid; t++) tick();
    chk("post_reset_valid", 64'(coeff_valid), 64'd1);
    chk("post_reset_coeff0", 64'(coeff), 64'd0);
    chk("post_reset_pos", 64'({poly_idx, coeff_idx}), 64'd0);

    // Random data with random valid/ready gaps.
    pops = 0;
    for (int t = 0; t < 20000 && !done; t++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      in_data     = $urandom;
      coeff_ready = ($urandom_range(0, 9) < 6);
      if (coeff_valid && coeff_ready) pops++;
      tick();
    end
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_pops", 64'(pops), 64'd2048);
    in_valid = 1'b0; coeff_ready = 1'b0;

    // widht=6 instance: straddling coefficient and range flag.
    s6_start = 1'b1; tick(); s6_start = 1'b0;
    chk("w6_busy", 64'(s6_busy), 64'd1);
    chk("w6_in_ready", 64'(s6_in_ready), 64'd1);
    s6_in_valid = 1'b1; s6_in_data = 32'hFFFFFFFF; tick();
    s6_in_data = 32'h0000000C; tick();
    s6_in_valid = 1'b0;
    chk("w6_valid", 64'(s6_coeff_valid), 64'd1);
    s6_coeff_ready = 1'b1;
    n6 = 0;
    for (int t = 0; t < 20 && n6 < 7; t++) begin
      if (s6_coeff_valid && s6_coeff_ready) begin
        got6[n6] = int'(s6_coeff);
        n6++;
      end
      tick();
    end
    s6_coeff_ready = 1'b0;
    chk("w6_count", 64'(n6), 64'd7);
    for (int i = 0; i < 7; i++) chk($sformatf("w6_coeff%0d", i), 64'(got6[i]), 64'(exp6[i]));
    chk("w6_coeff_idx", 64'(s6_coeff_idx), 64'd7);
    chk("w6_poly_idx", 64'(s6_poly_idx), 64'd0);
    chk("w6_not_done", 64'({s6_done, s6_coeff_last}), 64'd0);
    chk("w6_range_err", 64'(s6_range_err), 64'(RANGE_ON));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
